// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bundle layout, counter width, helpers.
package pipe_pkg;

  // Control bundle layout, MSB first
  localparam int unsigned CTRL_W_DEF          = 10;
  localparam int unsigned CTRL_REG_WRITE_BIT  = 9;
  localparam int unsigned CTRL_ALU_SRC_BIT    = 8;
  localparam int unsigned CTRL_MEM_WRITE_BIT  = 7;
  localparam int unsigned CTRL_RESULT_SRC_BIT = 6;
  localparam int unsigned CTRL_BRANCH_BIT     = 5;
  localparam int unsigned CTRL_IMM_SRC_MSB    = 4;
  localparam int unsigned CTRL_IMM_SRC_LSB    = 3;
  localparam int unsigned CTRL_ALU_CTRL_MSB   = 2;
  localparam int unsigned CTRL_ALU_CTRL_LSB   = 0;

  // Stall-cycle counter width
  localparam int unsigned CNT_W = 16;

  // Saturating increment for the stall counter
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare against the stage head entry and the one-cycle shadow.
module load_use_detect
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic              in_valid,
  input  logic              in_use_rs1,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic              in_use_rs2,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic              head_valid,
  input  logic              head_is_load,
  input  logic [REG_AW-1:0] head_rd,
  input  logic              shadow_valid,
  input  logic [REG_AW-1:0] shadow_rd,
  output logic              hazard_c
);

  logic head_hit;
  logic shadow_hit;

  // Incoming sources against a load's destination; x0 never hazards
  always_comb begin
    head_hit   = head_valid && head_is_load && (head_rd != '0) &&
                 ((in_use_rs1 && (in_rs1 == head_rd)) ||
                  (in_use_rs2 && (in_rs2 == head_rd)));
    shadow_hit = shadow_valid && (shadow_rd != '0) &&
                 ((in_use_rs1 && (in_rs1 == shadow_rd)) ||
                  (in_use_rs2 && (in_rs2 == shadow_rd)));
    hazard_c   = in_valid && (head_hit || shadow_hit);
  end

endmodule

// File: rtl/decode_exec_pipe_reg.sv
// Decode->execute pipeline register with load-use stall and flush.
// DECODE_SKID_BUF_EN: 2-entry skid buffer with registered not-full flag;
// otherwise a single entry whose in_ready follows out_ready.
module decode_exec_pipe_reg
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [XLEN-1:0]   in_rd1,
  input  logic [XLEN-1:0]   in_rd2,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_use_rs1,
  input  logic              in_use_rs2,
  input  logic              in_is_load,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [XLEN-1:0]   out_rd1,
  output logic [XLEN-1:0]   out_rd2,
  output logic [XLEN-1:0]   out_imm,
  output logic [XLEN-1:0]   out_pc,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_is_load,
  output logic              hazard_stall,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] rd;
    logic              is_load;
  } entry_t;

  entry_t            in_entry;
  entry_t            head;
  logic              head_valid;
  logic              hazard_c;
  logic              push;
  logic              pop;

  logic              shadow_valid_q, shadow_valid_d;
  logic [REG_AW-1:0] shadow_rd_q, shadow_rd_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

  assign in_entry = '{ctrl: in_ctrl, rd1: in_rd1, rd2: in_rd2, imm: in_imm,
                      pc: in_pc, rd: in_rd, is_load: in_is_load};

  load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
    .in_valid     (in_valid),
    .in_use_rs1   (in_use_rs1),
    .in_rs1       (in_rs1),
    .in_use_rs2   (in_use_rs2),
    .in_rs2       (in_rs2),
    .head_valid   (head_valid),
    .head_is_load (head.is_load),
    .head_rd      (head.rd),
    .shadow_valid (shadow_valid_q),
    .shadow_rd    (shadow_rd_q),
    .hazard_c     (hazard_c)
  );

  assign hazard_stall = hazard_c;
  assign push         = in_valid && in_ready;
  assign pop          = head_valid && out_ready;

`ifdef DECODE_SKID_BUF_EN
  entry_t     slot_q [2];
  entry_t     slot_d [2];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] count_q, count_d;
  logic       not_full_q, not_full_d;

  assign head_valid = (count_q != 2'd0);
  assign head       = slot_q[rd_ptr_q];
  assign in_ready   = not_full_q && !hazard_c;

  // Two-slot circular buffer; flush drops everything including this cycle's push
  always_comb begin
    slot_d     = slot_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    not_full_d = not_full_q;
    if (flush) begin
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
      count_d    = 2'd0;
      not_full_d = 1'b1;
    end else begin
      if (push) begin
        slot_d[wr_ptr_q] = in_entry;
        wr_ptr_d         = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d    = count_q + 2'(push) - 2'(pop);
      not_full_d = (count_d != 2'd2);
    end
  end

  // Skid buffer state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q[0]  <= '0;
      slot_q[1]  <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      not_full_q <= 1'b1;
    end else begin
      slot_q     <= slot_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      not_full_q <= not_full_d;
    end
  end
`else
  logic   valid_q, valid_d;
  entry_t entry_q, entry_d;

  assign head_valid = valid_q;
  assign head       = entry_q;
  assign in_ready   = (!valid_q || out_ready) && !hazard_c;

  // Single entry; a push replaces a departing entry in the same cycle
  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (flush) begin
      valid_d = 1'b0;
      entry_d = '0;
    end else if (push) begin
      valid_d = 1'b1;
      entry_d = in_entry;
    end else if (pop) begin
      valid_d = 1'b0;
      entry_d = '0;
    end
  end

  // Single-entry state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end
`endif

  // Shadow of a departing load's rd for one cycle, and saturating stall count
  always_comb begin
    shadow_valid_d = 1'b0;
    shadow_rd_d    = '0;
    if (pop && head.is_load && (head.rd != '0) && !flush) begin
      shadow_valid_d = 1'b1;
      shadow_rd_d    = head.rd;
    end
    bubble_cnt_d = hazard_c ? sat_inc(bubble_cnt_q) : bubble_cnt_q;
  end

  // Shadow and counter state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_valid_q <= 1'b0;
      shadow_rd_q    <= '0;
      bubble_cnt_q   <= '0;
    end else begin
      shadow_valid_q <= shadow_valid_d;
      shadow_rd_q    <= shadow_rd_d;
      bubble_cnt_q   <= bubble_cnt_d;
    end
  end

  // Head payload, forced to zero when no entry is presented
  assign out_valid   = head_valid;
  assign out_ctrl    = head_valid ? head.ctrl    : '0;
  assign out_rd1     = head_valid ? head.rd1     : '0;
  assign out_rd2     = head_valid ? head.rd2     : '0;
  assign out_imm     = head_valid ? head.imm     : '0;
  assign out_pc      = head_valid ? head.pc      : '0;
  assign out_rd      = head_valid ? head.rd      : '0;
  assign out_is_load = head_valid && head.is_load;
  assign bubble_cnt  = bubble_cnt_q;

endmodule

// File: doc/decode_exec_pipe_reg.md
DECODE_EXEC_PIPE_REG -- requirements
Module: decode_exec_pipe_reg

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width of register operands, immediate and PC.
REQ-002 SHALL have parameter CTRL_W, default 10, width of the packed control bundle (RegWrite, ALUSrc, MemWrite, ResultSrc, Branch, ImmSrc[1:0], ALUControl[2:0]).
REQ-003 SHALL have parameter REG_AW, default 5, register-index width.
REQ-004 SHALL have ports, clock and reset first:
 clk  in  1  single clock, rising edge
 rst  in  1  asynchronous, active-low reset
 in_valid  in  1  decode-side entry valid
 in_ready  out  1  stage can accept entry
 in_ctrl  in  CTRL_W  control bundle
 in_rd1, in_rd2, in_imm, in_pc  in  XLEN each  operands, extended immediate, PC
 in_rs1, in_rs2, in_rd  in  REG_AW each  source/destination indices
 in_use_rs1, in_use_rs2, in_is_load  in  1 each  source usage, load flag
 flush  in  1  synchronous pipeline kill (taken branch)
 out_valid  out  1  execute-side entry valid
 out_ready  in  1  execute accepts entry
 out_ctrl, out_rd1, out_rd2, out_imm, out_pc, out_rd, out_is_load  out  matching widths  head-entry payload
 hazard_stall  out  1  load-use stall active this cycle
 bubble_cnt  out  16  saturating count of stall cycles

Function
REQ-005 Transfer in SHALL occur on a cycle with in_valid && in_ready; transfer out on out_valid && out_ready.
REQ-006 Entries SHALL leave in FIFO order; payload SHALL be bit-exact; latency from transfer in to out_valid SHALL be 1 cycle when the stage is empty.
REQ-007 Payload outputs SHALL be 0 whenever out_valid is 0.
REQ-008 Hazard condition: head valid && out_is_load && out_rd != 0 && ((in_use_rs1 && in_rs1 == out_rd) || (in_use_rs2 && in_rs2 == out_rd)).
REQ-009 Shadow: on transfer out of a load with nonzero rd, a 1-cycle shadow register SHALL hold that rd; a matching in_rs1/in_rs2 (same usage gating) in the next cycle SHALL also be a hazard.
REQ-010 hazard_stall SHALL equal in_valid && hazard condition (head or shadow); when high, in_ready SHALL be 0.
REQ-011 bubble_cnt SHALL increment on each cycle hazard_stall is 1 and saturate at 16'hFFFF.
REQ-012 flush SHALL, at the next edge, clear all entries and the shadow; any transfer in during a flush cycle SHALL be discarded; bubble_cnt SHALL be unaffected.
REQ-013 Simultaneous transfer in and out with one entry held SHALL keep occupancy unchanged without a lost cycle.
REQ-014 in_rd == 0 loads SHALL never cause a stall.

Reset
REQ-015 While rst is 0, all entries, shadow and bubble_cnt SHALL clear asynchronously; out_valid, hazard_stall SHALL be 0, all payload outputs 0.
REQ-016 Reset asserted mid-transfer SHALL drop the in-flight entry; in_ready SHALL be 1 in the first cycle after release.

Configuration
REQ-017 With DECODE_SKID_BUF_EN defined: 2-entry skid buffer; in_ready SHALL be registered (= not full and no hazard), full throughput with out_ready toggling.
REQ-018 Without DECODE_SKID_BUF_EN: single entry; in_ready SHALL be (!out_valid || out_ready) && !hazard_stall, combinational from out_ready.

Structure
REQ-019 Control-bundle bit positions, CTRL_W default and the 16-bit counter width SHALL live in shared package pipe_pkg.
REQ-020 Hazard compare (REQ-008/009) SHALL be sub-module load_use_detect; storage SHALL be in decode_exec_pipe_reg.

Verification
REQ-021 Stream of 4 ALU entries, out_ready=1 -> each appears 1 cycle later, in order, hazard_stall never 1.
REQ-022 Load rd=5 at head, incoming in_rs1=5 in_use_rs1=1 -> hazard_stall=1 until load leaves plus 1 shadow cycle; bubble_cnt=2 with out_ready=1.
REQ-023 Load rd=0, incoming rs1=0 -> no stall, bubble_cnt stays 0.
REQ-024 Two entries held (skid build), flush=1 with in_valid=1 -> next cycle out_valid=0, no entry emerges.
REQ-025 out_ready alternating 1/0 for 10 entries -> no loss or duplication; with DECODE_SKID_BUF_EN in_ready never combinationally follows out_ready.
REQ-026 rst pulled low mid-stream -> out_valid, payload, bubble_cnt 0 immediately; in_ready=1 first cycle after release.
